// File: rtl/tug_position_ctrl.sv
// tug_position_ctrl: game core of the tug-of-war design.
//   Consumes one-cycle push pulses from the left and right players and tracks the rope
//   position. Runs the start countdown, drives the one-hot LED bar and the "go" indicator,
//   and declares the winner. A declared winner is held until clear or rst.
//
// Optional feature macro: FALSE_START_EN
//   defined   : a single-player push during the countdown loses the game immediately.
//   undefined : pushes during the countdown are ignored.
//
// Ports:
//   clk    in   1              system clock, all state on posedge
//   rst    in   1              asynchronous active-high reset
//   leftp  in   1              left player push pulse
//   rightp in   1              right player push pulse
//   clear  in   1              synchronous restart of the game from any state
//   leds   out  2*POS_HALF+1   one-hot rope position, MSB = left end, registered
//   go     out  1              high while play is running, registered
//   winl   out  1              left player has won, registered
//   winr   out  1              right player has won, registered
module tug_position_ctrl #(
  parameter int unsigned POS_HALF     = 3,
  parameter int unsigned START_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  leftp,
  input  logic                  rightp,
  input  logic                  clear,
  output logic [2*POS_HALF:0]   leds,
  output logic                  go,
  output logic                  winl,
  output logic                  winr
);

  localparam int unsigned LW = 2 * POS_HALF + 1;
  localparam int unsigned TW = $clog2(START_CYCLES + 1);
  localparam int unsigned PW = $clog2(LW);

  localparam logic [PW-1:0] PosCentre = PW'(POS_HALF);
  localparam logic [PW-1:0] PosLeft   = PW'(2 * POS_HALF);
  localparam logic [PW-1:0] PosRight  = '0;
  localparam logic [TW-1:0] TimerLast = TW'(START_CYCLES - 1);

  typedef enum logic [1:0] {StWait, StPlay, StWinL, StWinR} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [LW-1:0]   leds_q, leds_d;
  logic            go_q, go_d;
  logic            winl_q, winl_d;
  logic            winr_q, winr_d;

  // State register, including the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StWait;
      timer_q <= '0;
      pos_q   <= PosCentre;
      leds_q  <= LW'(1) << POS_HALF;
      go_q    <= 1'b0;
      winl_q  <= 1'b0;
      winr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pos_q   <= pos_d;
      leds_q  <= leds_d;
      go_q    <= go_d;
      winl_q  <= winl_d;
      winr_q  <= winr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pos_d   = pos_q;
    if (clear) begin
      state_d = StWait;
      timer_d = '0;
      pos_d   = PosCentre;
    end else begin
      unique case (state_q)
        StWait: begin
          timer_d = timer_q + TW'(1);
          if (timer_q == TimerLast) begin
            state_d = StPlay;
            timer_d = timer_q;
          end
`ifdef FALSE_START_EN
          // A lone push before go forfeits; a simultaneous push cancels out.
          if (leftp && !rightp) begin
            state_d = StWinR;
            pos_d   = PosRight;
          end else if (rightp && !leftp) begin
            state_d = StWinL;
            pos_d   = PosLeft;
          end
`endif
        end
        StPlay: begin
          if (leftp && !rightp) begin
            pos_d = pos_q + PW'(1);
          end else if (rightp && !leftp) begin
            pos_d = pos_q - PW'(1);
          end
          // Win is decided on the same edge as the move that reaches an end.
          if (pos_d == PosLeft) begin
            state_d = StWinL;
          end else if (pos_d == PosRight) begin
            state_d = StWinR;
          end
        end
        StWinL, StWinR: ;
        default: state_d = StWait;
      endcase
    end
  end

  // Output decode from the next state so the registered outputs track it without lag.
  always_comb begin
    leds_d = LW'(1) << pos_d;
    go_d   = (state_d == StPlay);
    winl_d = (state_d == StWinL);
    winr_d = (state_d == StWinR);
  end

  assign leds = leds_q;
  assign go   = go_q;
  assign winl = winl_q;
  assign winr = winr_q;

endmodule

// File: tb/tb_tug_position_ctrl.sv
// Directed bench for tug_position_ctrl with POS_HALF=3, START_CYCLES=4.
module tb_tug_position_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       leftp;
  logic       rightp;
  logic       clear;
  logic [6:0] leds;
  logic       go;
  logic       winl;
  logic       winr;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] Centre = 7'b0001000;

  tug_position_ctrl #(
    .POS_HALF    (3),
    .START_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .leftp (leftp),
    .rightp(rightp),
    .clear (clear),
    .leds  (leds),
    .go    (go),
    .winl  (winl),
    .winr  (winr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] el, input logic eg,
                         input logic ewl, input logic ewr);
    chk({tag, ".leds"}, 32'(leds), 32'(el));
    chk({tag, ".go"}, 32'(go), 32'(eg));
    chk({tag, ".winl"}, 32'(winl), 32'(ewl));
    chk({tag, ".winr"}, 32'(winr), 32'(ewr));
  endtask

  // Expects go low for edges-1 edges, then high on the next edge; leds stay centred.
  task automatic countdown(input string tag, input int edges);
    for (int i = 1; i < edges; i++) begin
      tick();
      chk_all({tag, ".wait"}, Centre, 1'b0, 1'b0, 1'b0);
    end
    tick();
    chk_all({tag, ".go"}, Centre, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; leftp = 1'b0; rightp = 1'b0; clear = 1'b0;
    #12;
    chk_all("reset", Centre, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    countdown("start", 4);

    // Left pushes, held high: one step per cycle, win on third.
    leftp = 1'b1;
    tick(); chk_all("l1", 7'b0010000, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("l2", 7'b0100000, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("l3", 7'b1000000, 1'b0, 1'b1, 1'b0);
    leftp = 1'b0; rightp = 1'b1;
    tick(); chk_all("winl_frozen", 7'b1000000, 1'b0, 1'b1, 1'b0);
    rightp = 1'b0;

    clear = 1'b1;
    tick(); chk_all("clear1", Centre, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    countdown("restart1", 4);

    // Tie is ignored, then right wins.
    leftp = 1'b1; rightp = 1'b1;
    tick(); chk_all("tie", Centre, 1'b1, 1'b0, 1'b0);
    leftp = 1'b0;
    tick(); chk_all("r1", 7'b0000100, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("r2", 7'b0000010, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("r3", 7'b0000001, 1'b0, 1'b0, 1'b1);
    rightp = 1'b0; leftp = 1'b1;
    tick(); chk_all("winr_frozen", 7'b0000001, 1'b0, 1'b0, 1'b1);
    leftp = 1'b0;

    clear = 1'b1;
    tick(); chk_all("clear2", Centre, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;

    // Push during countdown.
    leftp = 1'b1;
    tick();
    leftp = 1'b0;
`ifdef FALSE_START_EN
    chk_all("false_start", 7'b0000001, 1'b0, 1'b0, 1'b1);
    clear = 1'b1;
    tick(); chk_all("clear3", Centre, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    countdown("restart3", 4);
`else
    chk_all("wait_push", Centre, 1'b0, 1'b0, 1'b0);
    countdown("restart2", 3);
`endif

    // Asynchronous reset mid-play.
    leftp = 1'b1;
    tick(); chk_all("pre_rst", 7'b0010000, 1'b1, 1'b0, 1'b0);
    leftp = 1'b0;
    #2 rst = 1'b1;
    #1 chk_all("async_rst", Centre, 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b0;
    countdown("after_rst", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
